// File: rtl/pipelined_carry_increment_adder.sv
// Two-stage pipelined carry-increment adder/subtractor with valid/ready handshakes.
// Optional macro CIA_SAT_EN: on signed overflow the sum saturates to the signed extreme.
module pipelined_carry_increment_adder #(
  parameter int WIDTH = 16,
  parameter int GSIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG  = WIDTH / GSIZE;
  localparam int MSB = WIDTH - 1;

  generate
    if (GSIZE < 2 || GSIZE > WIDTH || (WIDTH % GSIZE) != 0) begin : g_bad_params
      $error("pipelined_carry_increment_adder: WIDTH must be a multiple of GSIZE, GSIZE in 2..WIDTH");
    end
  endgenerate

`ifdef CIA_SAT_EN
  function automatic logic signed [WIDTH-1:0] sat_fn(input logic signed [WIDTH-1:0] s,
                                                     input logic ovf_i,
                                                     input logic a_msb);
    if (!ovf_i) return s;
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  logic w_en;
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;

  logic [WIDTH-1:0] w_beff, w_p, w_g, w_lsum;
  logic [NG-1:0]    w_gg;
  logic             w_ceff;

  always_comb begin
    logic c_loc;
    c_loc  = 1'b0;
    w_beff = b ^ {WIDTH{sub}};
    w_ceff = cin ^ sub;
    w_p    = a ^ w_beff;
    w_g    = a & w_beff;
    w_lsum = '0;
    w_gg   = '0;
    // Each group ripples internally from carry-in 0; its carry-out is the group generate.
    for (int k = 0; k < NG; k++) begin
      c_loc = 1'b0;
      for (int j = 0; j < GSIZE; j++) begin
        w_lsum[k*GSIZE+j] = w_p[k*GSIZE+j] ^ c_loc;
        c_loc             = w_g[k*GSIZE+j] | (w_p[k*GSIZE+j] & c_loc);
      end
      w_gg[k] = c_loc;
    end
  end

  // ---- stage 1: local group sums, group generates, propagate vector ----
  logic             r_vld_p1;
  logic [WIDTH-1:0] r_lsum_p1, r_p_p1;
  logic [NG-1:0]    r_gg_p1;
  logic             r_ceff_p1, r_amsb_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_lsum_p1 <= '0;
      r_p_p1    <= '0;
      r_gg_p1   <= '0;
      r_ceff_p1 <= 1'b0;
      r_amsb_p1 <= 1'b0;
    end else if (w_en) begin
      r_vld_p1  <= in_valid;
      r_lsum_p1 <= w_lsum;
      r_p_p1    <= w_p;
      r_gg_p1   <= w_gg;
      r_ceff_p1 <= w_ceff;
      r_amsb_p1 <= a[MSB];
    end
  end

  logic [NG:0]             w_c;
  logic [NG-1:0]           w_gp;
  logic [WIDTH-1:0]        w_sum;
  logic signed [WIDTH-1:0] w_res;
  logic                    w_ovf;

  always_comb begin
    w_c    = '0;
    w_c[0] = r_ceff_p1;
    w_gp   = '0;
    w_sum  = '0;
    for (int k = 0; k < NG; k++) begin
      w_gp[k]                   = &r_p_p1[k*GSIZE +: GSIZE];
      w_sum[k*GSIZE +: GSIZE]   = r_lsum_p1[k*GSIZE +: GSIZE] + GSIZE'(w_c[k]);
      w_c[k+1]                  = r_gg_p1[k] | (w_gp[k] & w_c[k]);
    end
    // Operand MSBs agree exactly when the MSB propagate bit is 0.
    w_ovf = ~r_p_p1[MSB] & (w_sum[MSB] ^ r_amsb_p1);
`ifdef CIA_SAT_EN
    w_res = sat_fn(w_sum, w_ovf, r_amsb_p1);
`else
    w_res = w_sum;
`endif
  end

  // ---- stage 2: group carry resolution, increment, overflow ----
  logic             r_vld_p2;
  logic [WIDTH-1:0] r_sum_p2;
  logic             r_cout_p2, r_ovf_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_sum_p2  <= '0;
      r_cout_p2 <= 1'b0;
      r_ovf_p2  <= 1'b0;
    end else if (w_en) begin
      r_vld_p2  <= r_vld_p1;
      r_sum_p2  <= w_res;
      r_cout_p2 <= w_c[NG];
      r_ovf_p2  <= w_ovf;
    end
  end

  assign out_valid = r_vld_p2;
  assign sum       = r_sum_p2;
  assign cout      = r_cout_p2;
  assign ovf       = r_ovf_p2;

endmodule

// File: tb/tb_pipelined_carry_increment_adder.sv
// Scoreboard bench for pipelined_carry_increment_adder (WIDTH=16, GSIZE=4); honours CIA_SAT_EN.
module tb_pipelined_carry_increment_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef CIA_SAT_EN
  localparam logic [15:0] OVF_POS_SUM = 16'h7FFF;
  localparam logic [15:0] OVF_NEG_SUM = 16'h8000;
`else
  localparam logic [15:0] OVF_POS_SUM = 16'h8000;
  localparam logic [15:0] OVF_NEG_SUM = 16'h7FFF;
`endif

  pipelined_carry_increment_adder #(.WIDTH(16), .GSIZE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts,
                      input logic [15:0] es, input logic ec, input logic eo);
    int n = 0;
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_accept: in_ready stuck at 0, expected 1 within 50 cycles");
    end else begin
      e.s = es; e.c = ec; e.o = eo;
      q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: pops an expectation for every handshaked output beat and checks stall stability.
  logic        held = 1'b0;
  logic [15:0] held_sum = '0;
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (held) begin
      chk("stall_valid_held", out_valid, 1);
      chk("stall_sum_held", sum, held_sum);
    end
    held     = out_valid && !out_ready && !rst;
    held_sum = sum;
    if (out_valid && out_ready && !rst) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_beat: got sum=0x%0h with no beat outstanding, expected none", sum);
      end else begin
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.c);
        chk("ovf", ovf, e.o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    idle();
    drain();

    // A beat accepted one cycle before reset must never emerge.
    @(negedge clk);
    a = 16'h0123; b = 16'h0456; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("midrst_no_out", out_valid, 0);
    end

    fork
      begin
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0);
        send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0);
        send(16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);
        idle();
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_result", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) begin
          #1;
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_sum_held", sum, 16'h0004);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, OVF_POS_SUM, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, OVF_NEG_SUM, 1'b1, 1'b1);
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
